pwm_capture: RTL

Receive-side counterpart to the PWM generator: samples an external PWM waveform on a pin, measures its high time and period in clock cycles, and reconstructs the 8-bit duty value that produced it. It sits behind a `uio_in` input pin and feeds the measured duty back into the GPIO/display path. It also detects stuck-high and stuck-low lines so software can tell a 0%/100% duty from a dead input.

---
 rtl/pwm_capture_pkg.sv | 21 ++
 rtl/pwm_capture_sync_edge.sv | 39 +++
 rtl/pwm_capture.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: FSM encoding, widths and duty saturation.
package pwm_capture_pkg;

  localparam int unsigned CNT_W_DEF = 9;
  localparam int unsigned DUTY_W    = 8;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 8'd255;

  typedef logic [1:0] state_t;

  localparam state_t WAIT_EDGE = 2'd0;
  localparam state_t MEASURE   = 2'd1;
  localparam state_t STUCK     = 2'd2;

  // Clamp a high-time count to the 8-bit duty range.
  function automatic logic [DUTY_W-1:0] sat_duty(input int unsigned cnt);
    logic [31:0] c;
    c = cnt;
    return (c > 32'd255) ? DUTY_MAX : c[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// Pin synchronizer with registered rising/falling edge strobes.
// level, rise and fall are all taken from the same delayed sample, so a strobe is
// always aligned with the first cycle in which level shows the new value.
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_q;
  logic              level_q;
  logic              rise_q;
  logic              fall_q;

  // Synchronizer chain, delayed level and edge strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], din};
      level_q <= chain_q[STAGES-1];
      rise_q  <= chain_q[STAGES-1] & ~level_q;
      fall_q  <= ~chain_q[STAGES-1] & level_q;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of a pin waveform, reconstructs the
// 8-bit duty and flags lines stuck high or low for a full counter range.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  high_time,
  output logic [CNT_W-1:0]  period,
  output logic [DUTY_W-1:0] duty_out,
  output logic              valid,
  output logic              stuck_hi,
  output logic              stuck_lo
);

  localparam logic [CNT_W-1:0] TIMEOUT = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic pwm_s;
  logic rise;
  logic fall;

  sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk   (clk),
    .rst   (rst),
    .din   (pwm_in),
    .level (pwm_s),
    .rise  (rise),
    .fall  (fall)
  );

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  per_q, per_d;
  logic [CNT_W-1:0]  hi_q, hi_d;
  logic [CNT_W-1:0]  high_time_q, high_time_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              valid_q, valid_d;
  logic              stuck_hi_q, stuck_hi_d;
  logic              stuck_lo_q, stuck_lo_d;
  logic              timeout;

  assign timeout = (per_q == TIMEOUT);

  // Next-state logic for the measurement FSM, counters and result registers.
  always_comb begin
    state_d     = state_q;
    per_d       = per_q;
    hi_d        = hi_q;
    high_time_d = high_time_q;
    period_d    = period_q;
    duty_d      = duty_q;
    valid_d     = 1'b0;
    stuck_hi_d  = stuck_hi_q;
    stuck_lo_d  = stuck_lo_q;

    if (!en) begin
      state_d = WAIT_EDGE;
      per_d   = '0;
      hi_d    = '0;
    end else if (rise) begin
      // A rising edge always wins over a coincident timeout.
      if (state_q == MEASURE) begin
        period_d    = per_q;
        high_time_d = hi_q;
        duty_d      = sat_duty(32'(hi_q));
        valid_d     = 1'b1;
        stuck_hi_d  = 1'b0;
        stuck_lo_d  = 1'b0;
      end
      state_d = MEASURE;
      per_d   = CNT_ONE;
      hi_d    = CNT_ONE;
    end else begin
      unique case (state_q)
        WAIT_EDGE, MEASURE: begin
          if (timeout) begin
            state_d     = STUCK;
            stuck_hi_d  = pwm_s;
            stuck_lo_d  = ~pwm_s;
            period_d    = '0;
            high_time_d = '0;
            duty_d      = pwm_s ? DUTY_MAX : '0;
            valid_d     = 1'b1;
          end else begin
            per_d = per_q + CNT_ONE;
            hi_d  = (state_q == MEASURE) ? hi_q + {{(CNT_W-1){1'b0}}, pwm_s} : '0;
          end
        end
        STUCK: begin
          // A high line that drops while stuck is reported as stuck low, silently.
          if (stuck_hi_q && fall) begin
            stuck_hi_d = 1'b0;
            stuck_lo_d = 1'b1;
            duty_d     = '0;
          end
        end
        default: begin
          state_d = WAIT_EDGE;
          per_d   = '0;
          hi_d    = '0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_EDGE;
      per_q       <= '0;
      hi_q        <= '0;
      high_time_q <= '0;
      period_q    <= '0;
      duty_q      <= '0;
      valid_q     <= 1'b0;
      stuck_hi_q  <= 1'b0;
      stuck_lo_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      per_q       <= per_d;
      hi_q        <= hi_d;
      high_time_q <= high_time_d;
      period_q    <= period_d;
      duty_q      <= duty_d;
      valid_q     <= valid_d;
      stuck_hi_q  <= stuck_hi_d;
      stuck_lo_q  <= stuck_lo_d;
    end
  end

  assign high_time = high_time_q;
  assign period    = period_q;
  assign duty_out  = duty_q;
  assign valid     = valid_q;
  assign stuck_hi  = stuck_hi_q;
  assign stuck_lo  = stuck_lo_q;

endmodule
